apb_slave: RTL and testbench
============================

APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 8-bit registers, addresses 0..DEPTH-1, range 2..128.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted per transfer, range 0..15.
REQ-003 SHALL have parameter ID_VALUE, default 8'hA5, read-only contents of address 0.
REQ-004 SHALL have port PCLK  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port PRESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port PSELECT  input  1  slave select from master.
REQ-007 SHALL have port PENABLE  input  1  access-phase indicator.
REQ-008 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-009 SHALL have port PADDR  input  7  byte address.
REQ-010 SHALL have port PWDATA  input  8  write data.
REQ-011 SHALL have port PRDATA  output  8  read data, registered.
REQ-012 SHALL have port PREADY  output  1  transfer-complete, registered.
REQ-013 SHALL have port PSLVERR  output  1  transfer error, registered, valid only while PREADY=1.

Function
REQ-014 SHALL implement states IDLE and ACCESS.
REQ-015 IDLE, edge with PSELECT=1 and PENABLE=0 (setup): SHALL go to ACCESS, latch PADDR/PWRITE/PWDATA, and load the wait counter with WAIT_CYCLES.
REQ-016 When the loaded count is 0, the setup edge SHALL perform the access and set PREADY<=1. This gives zero-wait completion at the end of the first access cycle.
REQ-017 ACCESS with PREADY=0: each edge SHALL decrement the counter. The edge where the counter equals 1 SHALL perform the access and set PREADY<=1.
REQ-018 ACCESS with PREADY=1: the next edge SHALL clear PREADY and PSLVERR and go to IDLE. A following setup is accepted from IDLE on the next cycle.
REQ-019 The access SHALL be performed exactly once per transfer, using latched address and data.
REQ-020 A write SHALL update mem[addr]. A read SHALL load PRDATA<=mem[addr], or PRDATA<=ID_VALUE when addr=0.
REQ-021 Error conditions:
- addr >= DEPTH: read or write;
- addr = 0: write.
REQ-022 On an error, the access SHALL set PSLVERR<=1 with PREADY and SHALL NOT modify any register. Error reads SHALL return PRDATA=8'h00.
REQ-023 If PSELECT=0 in ACCESS before PREADY is set, the slave SHALL abort to IDLE with no register update and PREADY=0.
REQ-024 PENABLE=1 seen in IDLE (protocol violation) SHALL be ignored.
REQ-025 PRDATA SHALL hold its last value outside read completions.

Reset
REQ-026 When PRESET=1 at an edge:
- state <= IDLE;
- PREADY, PSLVERR <= 0;
- PRDATA <= 8'h00;
- wait counter <= 0;
- all registers 1..DEPTH-1 <= 8'h00.
REQ-027 Reset SHALL abort any in-flight transfer with no register update. Reset SHALL dominate all other inputs.

Configuration
REQ-028 The macro APB_SLAVE_WAIT_EN SHALL control wait-state support.
- Defined: WAIT_CYCLES SHALL be honoured as specified.
- Undefined: the counter logic SHALL be absent, every transfer SHALL behave as WAIT_CYCLES=0, and the parameter SHALL be ignored.

Structure
REQ-029 Package apb_pkg SHALL hold:
- address width 7;
- data width 8;
- the IDLE/ACCESS state encoding;
- the default ID constant 8'hA5.
REQ-030 Register storage SHALL be a sub-module apb_slave_regfile with these ports:
- one synchronous write port with write enable;
- one combinational read port;
- synchronous reset of all entries to 8'h00.

Verification
REQ-031 Reset check: hold PRESET for 2 cycles, then release -> PREADY=0, PSLVERR=0, PRDATA=8'h00; read of addr 5 returns 8'h00.
REQ-032 Write/read with WAIT_CYCLES=1:
- write 8'h3C to addr 5 -> PREADY high in the second access cycle, PSLVERR=0;
- read addr 5 -> PRDATA=8'h3C.
REQ-033 Zero-wait back-to-back with WAIT_CYCLES=0 or macro undefined:
- write 8'h11 to addr 1, then 8'h22 to addr 2 -> each PREADY high in its first access cycle;
- reads return 8'h11 and 8'h22.
REQ-034 Errors:
- write to addr 0 -> PSLVERR=1, read of addr 0 still returns 8'hA5;
- read addr 7'd40 with DEPTH=32 -> PSLVERR=1, PRDATA=8'h00.
REQ-035 Abort with WAIT_CYCLES=3:
- drop PSELECT in the second access cycle of a write of 8'hFF to addr 4 -> PREADY never set, addr 4 still reads 8'h00;
- assert PRESET during a wait -> IDLE next cycle, no update.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared widths, state encoding and default ID byte for the APB register slave.
package apb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] ID_DEFAULT = 8'hA5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x 8-bit register file: one synchronous write port, one combinational read port,
// synchronous reset of every entry. Out-of-range addresses never write and read as zero.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && ({1'b0, waddr_i} < DEPTH_W)) begin
            mem_q[waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if ({1'b0, raddr_i} < DEPTH_W) begin
            rdata_o = mem_q[raddr_i[IW-1:0]];
        end
    end

endmodule

// File: rtl/apb_slave.sv
// APB register slave with read-only ID byte at address 0 and optional wait states.
// Wait-state counter exists only when APB_SLAVE_WAIT_EN is defined; otherwise every transfer is zero-wait.
module apb_slave
    import apb_pkg::*;
#(
    parameter int                DEPTH       = 32,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = ID_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELECT,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

`ifdef APB_SLAVE_WAIT_EN
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    logic [3:0] cnt_q, cnt_d;
`else
    localparam int unusedWaitCycles = WAIT_CYCLES;
`endif

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;

    logic              do_access;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_write;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_err;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;

    apb_slave_regfile #(
        .DEPTH(DEPTH)
    ) u_regfile (
        .clk_i  (PCLK),
        .reset_i(PRESET),
        .we_i   (rf_we),
        .waddr_i(acc_addr),
        .wdata_i(acc_wdata),
        .raddr_i(acc_addr),
        .rdata_o(rf_rdata)
    );

    // A zero-wait access uses the live bus values on the setup edge; later accesses use the latched copy.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
`ifdef APB_SLAVE_WAIT_EN
        cnt_d     = cnt_q;
`endif
        do_access = 1'b0;
        acc_addr  = addr_q;
        acc_write = write_q;
        acc_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (PSELECT && !PENABLE) begin
                    state_d   = ACCESS;
                    addr_d    = PADDR;
                    write_d   = PWRITE;
                    wdata_d   = PWDATA;
                    acc_addr  = PADDR;
                    acc_write = PWRITE;
                    acc_wdata = PWDATA;
`ifdef APB_SLAVE_WAIT_EN
                    cnt_d     = WAIT_LD;
                    do_access = (WAIT_LD == 4'd0);
`else
                    do_access = 1'b1;
`endif
                end
            end
            ACCESS: begin
                if (pready_q) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (!PSELECT) begin
                    state_d = IDLE;
                end
`ifdef APB_SLAVE_WAIT_EN
                else begin
                    cnt_d     = cnt_q - 4'd1;
                    do_access = (cnt_q == 4'd1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        acc_err = ({1'b0, acc_addr} >= DEPTH_W) || (acc_write && (acc_addr == '0));
        rf_we   = do_access && acc_write && !acc_err;

        if (do_access) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            if (!acc_write) begin
                prdata_d = acc_err ? '0 : ((acc_addr == '0) ? ID_VALUE : rf_rdata);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
`ifdef APB_SLAVE_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: three instances (WAIT_CYCLES 0, 1, 3) share one bus, each with its own select.
module tb_apb_slave;

    localparam int DEPTH = 32;
    localparam logic [7:0] ID = 8'hA5;

    logic       clk;
    logic       preset;
    logic       penable;
    logic       pwrite;
    logic [6:0] paddr;
    logic [7:0] pwdata;
    logic       psel    [3];
    logic [7:0] prdata  [3];
    logic       pready  [3];
    logic       pslverr [3];

    int         total;
    int         bad;
    int         effW    [3];
    logic [7:0] mdl     [3][128];
    logic [7:0] lastRd  [3];

    apb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
        .PCLK(clk), .PRESET(preset), .PSELECT(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
    apb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .ID_VALUE(ID)) dut1 (
        .PCLK(clk), .PRESET(preset), .PSELECT(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
    apb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .ID_VALUE(ID)) dut2 (
        .PCLK(clk), .PRESET(preset), .PSELECT(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < 3; k++) begin
            lastRd[k] = 8'h00;
            for (int a = 0; a < 128; a++) mdl[k][a] = 8'h00;
        end
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        preset = 1'b1;
        repeat (cycles) @(negedge clk);
        preset = 1'b0;
        clearModel();
    endtask

    // Full transfer on instance k, checked against the rule-based model.
    task automatic applyStimulus(input int k, input bit wr, input logic [6:0] a,
                                 input logic [7:0] d, input string tag);
        int         n;
        bit         seen;
        bit         expErr;
        logic [7:0] expRd;
        expErr = (int'(a) >= DEPTH) || (wr && a == 7'd0);
        expRd  = expErr ? 8'h00 : ((a == 7'd0) ? ID : mdl[k][a]);
        @(negedge clk);
        psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            if (pready[k]) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput({tag, ":cycles"}, n, effW[k] + 1);
        checkOutput({tag, ":err"}, {31'd0, pslverr[k]}, {31'd0, expErr});
        if (wr) begin
            checkOutput({tag, ":hold"}, {24'd0, prdata[k]}, {24'd0, lastRd[k]});
            if (!expErr) mdl[k][a] = d;
        end else begin
            checkOutput({tag, ":rdata"}, {24'd0, prdata[k]}, {24'd0, expRd});
            lastRd[k] = expRd;
        end
        @(negedge clk);
        psel[k] = 1'b0; penable = 1'b0;
        checkOutput({tag, ":done"}, {31'd0, pready[k]}, 32'd0);
    endtask

    // Write whose select is dropped in access cycle abortCycle.
    task automatic abortXfer(input int k, input logic [6:0] a, input logic [7:0] d, input int abortCycle);
        @(negedge clk);
        psel[k] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        for (int n = 1; n <= abortCycle; n++) begin
            if (n == abortCycle) begin
                psel[k] = 1'b0; penable = 1'b0;
            end
            checkOutput("abort:ready", {31'd0, pready[k]}, {31'd0, (n == effW[k] + 1)});
            @(negedge clk);
        end
        checkOutput("abort:after", {31'd0, pready[k]}, 32'd0);
        if (effW[k] <= abortCycle - 1 && a != 7'd0 && int'(a) < DEPTH) mdl[k][a] = d;
    endtask

    // Reset asserted in the second access cycle of a write.
    task automatic resetDuringWait(input int k, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        psel[k] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        checkOutput("rstwait:ready1", {31'd0, pready[k]}, {31'd0, (effW[k] == 0)});
        @(negedge clk);
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0; psel[k] = 1'b0; penable = 1'b0;
        clearModel();
        checkOutput("rstwait:ready", {31'd0, pready[k]}, 32'd0);
        checkOutput("rstwait:prdata", {24'd0, prdata[k]}, 32'd0);
    endtask

    // PENABLE with select while idle must not start anything.
    task automatic idleGlitch(input int k);
        @(negedge clk);
        psel[k] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 7'd3; pwdata = 8'h5A;
        @(negedge clk);
        checkOutput("glitch:ready", {31'd0, pready[k]}, 32'd0);
        psel[k] = 1'b0; penable = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
`ifdef APB_SLAVE_WAIT_EN
        effW[0] = 0; effW[1] = 1; effW[2] = 3;
`else
        effW[0] = 0; effW[1] = 0; effW[2] = 0;
`endif
        preset = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        for (int k = 0; k < 3; k++) psel[k] = 1'b0;
        clearModel();

        doReset(2);
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset:ready", {31'd0, pready[k]}, 32'd0);
            checkOutput("reset:err", {31'd0, pslverr[k]}, 32'd0);
            checkOutput("reset:prdata", {24'd0, prdata[k]}, 32'd0);
        end
        applyStimulus(0, 1'b0, 7'd5, 8'h00, "reset:rd5");

        applyStimulus(1, 1'b1, 7'd5, 8'h3C, "w1:wr5");
        applyStimulus(1, 1'b0, 7'd5, 8'h00, "w1:rd5");

        applyStimulus(0, 1'b1, 7'd1, 8'h11, "z:wr1");
        applyStimulus(0, 1'b1, 7'd2, 8'h22, "z:wr2");
        applyStimulus(0, 1'b0, 7'd1, 8'h00, "z:rd1");
        applyStimulus(0, 1'b0, 7'd2, 8'h00, "z:rd2");

        applyStimulus(1, 1'b1, 7'd0, 8'h77, "err:wr0");
        applyStimulus(1, 1'b0, 7'd0, 8'h00, "err:rd0");
        applyStimulus(1, 1'b0, 7'd40, 8'h00, "err:rd40");
        applyStimulus(2, 1'b1, 7'd31, 8'h9D, "edge:wr31");
        applyStimulus(2, 1'b0, 7'd31, 8'h00, "edge:rd31");
        applyStimulus(2, 1'b1, 7'd32, 8'h44, "edge:wr32");

        idleGlitch(2);
        abortXfer(2, 7'd4, 8'hFF, 2);
        applyStimulus(2, 1'b0, 7'd4, 8'h00, "abort:rd4");

        applyStimulus(2, 1'b1, 7'd6, 8'h66, "pre:wr6");
        resetDuringWait(2, 7'd4, 8'hEE);
        applyStimulus(2, 1'b0, 7'd4, 8'h00, "rstwait:rd4");
        applyStimulus(2, 1'b0, 7'd6, 8'h00, "rstwait:rd6");

        for (int i = 0; i < 80; i++) begin
            int         k;
            bit         wr;
            logic [6:0] a;
            logic [7:0] d;
            k  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(32, 127));
            else a = 7'($urandom_range(0, 31));
            d  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) idleGlitch(k);
            applyStimulus(k, wr, a, d, wr ? "rand:wr" : "rand:rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
